rf_ctrl: RTL and testbench

Command sequencer that drives the port interface of the 8x16b register file (`rf`). It accepts register-file commands over a valid/ready handshake, expands them into single- or multi-cycle port activity (READ, WRITE, COPY, SWAP, CLEAR), and returns a response over a second valid/ready handshake. It sits between a test/debug master and `rf`; all `rf` inputs come from this block.

---
 rtl/rf_ctrl_pkg.sv | 23 ++
 rtl/rf_ctrl_seq.sv | 58 +++++
 rtl/rf_ctrl.sv | 166 ++++++++++++++++
 tb/tb_rf_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/rf_ctrl_pkg.sv
// Shared definitions for rf_ctrl: op codes, sequencer states and port widths.
// The CLEAR op is only built when RF_CTRL_CLEAR_EN is defined.
package rf_ctrl_pkg;

  localparam int DATA_W = 16;
  localparam int SEL_W  = 3;
  localparam int OP_W   = 3;

  localparam logic [OP_W-1:0] OP_READ  = 3'd0;
  localparam logic [OP_W-1:0] OP_WRITE = 3'd1;
  localparam logic [OP_W-1:0] OP_COPY  = 3'd2;
  localparam logic [OP_W-1:0] OP_SWAP  = 3'd3;
  localparam logic [OP_W-1:0] OP_CLEAR = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_EXEC  = 3'd1,
    S_SWAP2 = 3'd2,
    S_CLR   = 3'd3,
    S_RESP  = 3'd4
  } state_e;

endpackage

// File: rtl/rf_ctrl_seq.sv
// State register, next-state logic and CLR sweep counter for rf_ctrl.
// The counter and CLR path exist only when RF_CTRL_CLEAR_EN is defined.
module rf_ctrl_seq
  import rf_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            accept_i,
  input  logic [OP_W-1:0] op_i,
  input  logic            rsp_ready_i,
`ifdef RF_CTRL_CLEAR_EN
  output logic [SEL_W-1:0] cnt_o,
`endif
  output state_e          state_o
);

  state_e state_q;
`ifdef RF_CTRL_CLEAR_EN
  logic [SEL_W-1:0] cnt_q;
  assign cnt_o = cnt_q;
`endif
  assign state_o = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
`ifdef RF_CTRL_CLEAR_EN
      cnt_q   <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: if (accept_i) state_q <= S_EXEC;
        S_EXEC: begin
          if (op_i == OP_SWAP) state_q <= S_SWAP2;
`ifdef RF_CTRL_CLEAR_EN
          else if (op_i == OP_CLEAR) state_q <= S_CLR;
`endif
          else state_q <= S_RESP;
        end
        S_SWAP2: state_q <= S_RESP;
`ifdef RF_CTRL_CLEAR_EN
        // Exactly eight sweep cycles; the counter is rearmed on exit.
        S_CLR: begin
          if (cnt_q == 3'd7) begin
            state_q <= S_RESP;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
`endif
        S_RESP: if (rsp_ready_i) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/rf_ctrl.sv
// Command sequencer driving the 8x16b register file port (READ/WRITE/COPY/SWAP/CLEAR).
// Optional CLEAR sweep is enabled with the RF_CTRL_CLEAR_EN macro.
module rf_ctrl
  import rf_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [SEL_W-1:0]  cmd_ra,
  input  logic [SEL_W-1:0]  cmd_rb,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data1,
  output logic [DATA_W-1:0] rsp_data2,
  output logic              rsp_err,
  output logic [SEL_W-1:0]  readReg1Sel,
  output logic [SEL_W-1:0]  readReg2Sel,
  output logic [SEL_W-1:0]  writeRegSel,
  output logic [DATA_W-1:0] writeData,
  output logic              writeEn,
  output logic              enable,
  input  logic [DATA_W-1:0] readData1,
  input  logic [DATA_W-1:0] readData2,
  input  logic              rfErr
);

  state_e            state;
  logic              accept;
  logic              op_legal;
  logic [OP_W-1:0]   op_q;
  logic [SEL_W-1:0]  ra_q, rb_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] d1_q, d1_d, d2_q, d2_d;
  logic              err_q, err_d;
`ifdef RF_CTRL_CLEAR_EN
  logic [SEL_W-1:0]  cnt;
`endif

  assign cmd_ready = (state == S_IDLE) & ~rst;
  assign accept    = cmd_valid & cmd_ready;
  assign rsp_valid = (state == S_RESP);
  assign rsp_data1 = d1_q;
  assign rsp_data2 = d2_q;
  assign rsp_err   = err_q;

`ifdef RF_CTRL_CLEAR_EN
  assign op_legal = (op_q <= OP_CLEAR);
`else
  assign op_legal = (op_q <= OP_SWAP);
`endif

  rf_ctrl_seq u_seq (
    .clk        (clk),
    .rst        (rst),
    .accept_i   (accept),
    .op_i       (op_q),
    .rsp_ready_i(rsp_ready),
`ifdef RF_CTRL_CLEAR_EN
    .cnt_o      (cnt),
`endif
    .state_o    (state)
  );

  // rf port drive: decoded from state and the latched command only.
  always_comb begin
    readReg1Sel = '0;
    readReg2Sel = '0;
    writeRegSel = '0;
    writeData   = '0;
    writeEn     = 1'b0;
    enable      = 1'b0;
    case (state)
      S_EXEC: begin
        enable = op_legal;
        case (op_q)
          OP_READ: begin
            readReg1Sel = ra_q;
            readReg2Sel = rb_q;
          end
          OP_WRITE: begin
            writeRegSel = ra_q;
            writeData   = data_q;
            writeEn     = 1'b1;
          end
          OP_COPY: begin
            readReg1Sel = ra_q;
            writeRegSel = rb_q;
            writeData   = readData1;
            writeEn     = 1'b1;
          end
          OP_SWAP: begin
            readReg1Sel = ra_q;
            readReg2Sel = rb_q;
            writeRegSel = ra_q;
            writeData   = readData2;
            writeEn     = 1'b1;
          end
          default: ;
        endcase
      end
      S_SWAP2: begin
        enable      = 1'b1;
        writeRegSel = rb_q;
        writeData   = d1_q;
        writeEn     = 1'b1;
      end
`ifdef RF_CTRL_CLEAR_EN
      S_CLR: begin
        enable      = 1'b1;
        writeRegSel = cnt;
        writeEn     = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    d1_d  = d1_q;
    d2_d  = d2_q;
    err_d = err_q;
    if (accept) begin
      d1_d  = '0;
      d2_d  = '0;
      err_d = 1'b0;
    end else if (state == S_EXEC) begin
      case (op_q)
        OP_READ, OP_SWAP: begin
          d1_d = readData1;
          d2_d = readData2;
        end
        OP_WRITE: d1_d = data_q;
        OP_COPY:  d1_d = readData1;
        default: ;
      endcase
      if (!op_legal) err_d = 1'b1;
    end
    if (enable && rfErr) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= '0;
      ra_q   <= '0;
      rb_q   <= '0;
      data_q <= '0;
      d1_q   <= '0;
      d2_q   <= '0;
      err_q  <= 1'b0;
    end else begin
      if (accept) begin
        op_q   <= cmd_op;
        ra_q   <= cmd_ra;
        rb_q   <= cmd_rb;
        data_q <= cmd_data;
      end
      d1_q  <= d1_d;
      d2_q  <= d2_d;
      err_q <= err_d;
    end
  end

endmodule

// File: tb/tb_rf_ctrl.sv
// Directed bench for rf_ctrl with a behavioural 8x16 register file model.
// CLEAR-specific vectors follow RF_CTRL_CLEAR_EN.
module tb_rf_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = '0, cmd_ra = '0, cmd_rb = '0;
  logic [15:0] cmd_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data1, rsp_data2;
  logic        rsp_err;
  logic [2:0]  readReg1Sel, readReg2Sel, writeRegSel;
  logic [15:0] writeData;
  logic        writeEn, enable;
  logic [15:0] readData1, readData2;
  logic        rfErr = 1'b0;

  logic [15:0] rf_mem [8] = '{default: 16'h0000};

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign readData1 = rf_mem[readReg1Sel];
  assign readData2 = rf_mem[readReg2Sel];
  always @(posedge clk) if (enable && writeEn) rf_mem[writeRegSel] <= writeData;

  rf_ctrl dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data1(rsp_data1), .rsp_data2(rsp_data2), .rsp_err(rsp_err),
    .readReg1Sel(readReg1Sel), .readReg2Sel(readReg2Sel), .writeRegSel(writeRegSel),
    .writeData(writeData), .writeEn(writeEn), .enable(enable),
    .readData1(readData1), .readData2(readData2), .rfErr(rfErr)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one command; lat is the cycle (relative to accept cycle A) where rsp_valid is seen.
  task automatic do_cmd(input logic [2:0] op, input logic [2:0] ra, input logic [2:0] rb,
                        input logic [15:0] data, output logic [15:0] d1, output logic [15:0] d2,
                        output logic err, output int lat, output int we_n,
                        output logic saw_en, output logic sel_ok);
    int w;
    w = 0;
    while (!cmd_ready && w < 20) begin step(); w++; end
    check("cmd_ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_ra = ra; cmd_rb = rb; cmd_data = data;
    step();
    cmd_valid = 1'b0;
    lat = 1; we_n = 0; saw_en = 1'b0; sel_ok = 1'b1;
    while (!rsp_valid && lat < 40) begin
      if (enable) saw_en = 1'b1;
      if (writeEn) begin
        if (op == 3'd4 && writeRegSel != we_n[2:0]) sel_ok = 1'b0;
        we_n++;
      end
      step();
      lat++;
    end
    if (lat >= 40) check("rsp_timeout", 32'(lat), 32'd0);
    d1 = rsp_data1; d2 = rsp_data2; err = rsp_err;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] d1, d2;
    logic        err, saw_en, sel_ok;
    int          lat, we_n;

    // Reset state
    step(); step();
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_err",   {31'd0, rsp_err},   32'd0);
    check("rst_rsp_data",  {rsp_data1, rsp_data2}, 32'd0);
    check("rst_rf_drive",  {26'd0, enable, writeEn, writeRegSel}, 32'd0);
    rst = 1'b0;
    step();
    check("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // WRITE then READ
    do_cmd(3'd1, 3'd3, 3'd0, 16'hBEEF, d1, d2, err, lat, we_n, saw_en, sel_ok);
    check("wr_d1", {16'd0, d1}, 32'h0000BEEF);
    check("wr_d2", {16'd0, d2}, 32'd0);
    check("wr_lat", 32'(lat), 32'd2);
    check("wr_we_n", 32'(we_n), 32'd1);
    do_cmd(3'd0, 3'd3, 3'd0, 16'h0, d1, d2, err, lat, we_n, saw_en, sel_ok);
    check("rd_data", {d1, d2}, 32'hBEEF0000);
    check("rd_lat", 32'(lat), 32'd2);
    check("rd_err", {31'd0, err}, 32'd0);

    // SWAP
    do_cmd(3'd1, 3'd1, 3'd0, 16'h1234, d1, d2, err, lat, we_n, saw_en, sel_ok);
    do_cmd(3'd1, 3'd2, 3'd0, 16'hABCD, d1, d2, err, lat, we_n, saw_en, sel_ok);
    do_cmd(3'd3, 3'd1, 3'd2, 16'h0, d1, d2, err, lat, we_n, saw_en, sel_ok);
    check("swap_rsp", {d1, d2}, 32'h1234ABCD);
    check("swap_lat", 32'(lat), 32'd3);
    check("swap_we_n", 32'(we_n), 32'd2);
    do_cmd(3'd0, 3'd1, 3'd2, 16'h0, d1, d2, err, lat, we_n, saw_en, sel_ok);
    check("swap_readback", {d1, d2}, 32'hABCD1234);
    do_cmd(3'd3, 3'd3, 3'd3, 16'h0, d1, d2, err, lat, we_n, saw_en, sel_ok);
    do_cmd(3'd0, 3'd3, 3'd3, 16'h0, d1, d2, err, lat, we_n, saw_en, sel_ok);
    check("swap_same_reg", {d1, d2}, 32'hBEEFBEEF);

    // COPY
    do_cmd(3'd1, 3'd2, 3'd0, 16'h00FF, d1, d2, err, lat, we_n, saw_en, sel_ok);
    do_cmd(3'd2, 3'd2, 3'd5, 16'h0, d1, d2, err, lat, we_n, saw_en, sel_ok);
    check("copy_rsp", {16'd0, d1}, 32'h000000FF);
    check("copy_lat", 32'(lat), 32'd2);
    do_cmd(3'd0, 3'd5, 3'd0, 16'h0, d1, d2, err, lat, we_n, saw_en, sel_ok);
    check("copy_readback", {16'd0, d1}, 32'h000000FF);

    // Response backpressure: hold rsp_ready low, offer a competing command
    cmd_valid = 1'b1; cmd_op = 3'd0; cmd_ra = 3'd3; cmd_rb = 3'd5;
    step();
    cmd_op = 3'd1; cmd_ra = 3'd0; cmd_data = 16'h5555;
    step();
    check("bp_valid_a2", {31'd0, rsp_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold", {13'd0, rsp_valid, cmd_ready, writeEn, rsp_data1}, {13'd0, 3'b100, 16'hBEEF});
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    check("bp_release_idle", {30'd0, cmd_ready, rsp_valid}, 32'd2);
    do_cmd(3'd0, 3'd0, 3'd0, 16'h0, d1, d2, err, lat, we_n, saw_en, sel_ok);
    check("bp_no_stray_write", {16'd0, d1}, 32'd0);

    // Illegal op
    do_cmd(3'd6, 3'd1, 3'd2, 16'h7777, d1, d2, err, lat, we_n, saw_en, sel_ok);
    check("ill_err", {31'd0, err}, 32'd1);
    check("ill_no_enable", {31'd0, saw_en}, 32'd0);
    check("ill_data", {d1, d2}, 32'd0);
    check("ill_lat", 32'(lat), 32'd2);

    // rf error flag sets rsp_err, next accept clears it
    rfErr = 1'b1;
    do_cmd(3'd1, 3'd6, 3'd0, 16'h0006, d1, d2, err, lat, we_n, saw_en, sel_ok);
    rfErr = 1'b0;
    check("rferr_set", {31'd0, err}, 32'd1);
    do_cmd(3'd0, 3'd6, 3'd0, 16'h0, d1, d2, err, lat, we_n, saw_en, sel_ok);
    check("rferr_cleared", {15'd0, err, d1}, 32'h00000006);

    // CLEAR
    for (int r = 0; r < 8; r++)
      do_cmd(3'd1, 3'(r), 3'd0, 16'hFFFF, d1, d2, err, lat, we_n, saw_en, sel_ok);
    do_cmd(3'd4, 3'd0, 3'd0, 16'h0, d1, d2, err, lat, we_n, saw_en, sel_ok);
`ifdef RF_CTRL_CLEAR_EN
    check("clr_err", {31'd0, err}, 32'd0);
    check("clr_lat", 32'(lat), 32'd10);
    check("clr_we_n", 32'(we_n), 32'd8);
    check("clr_sel_seq", {31'd0, sel_ok}, 32'd1);
    for (int r = 0; r < 8; r += 2) begin
      do_cmd(3'd0, 3'(r), 3'(r + 1), 16'h0, d1, d2, err, lat, we_n, saw_en, sel_ok);
      check("clr_readback", {d1, d2}, 32'd0);
    end

    // Reset during the CLR sweep
    for (int r = 0; r < 8; r++)
      do_cmd(3'd1, 3'(r), 3'd0, 16'hFFFF, d1, d2, err, lat, we_n, saw_en, sel_ok);
    cmd_valid = 1'b1; cmd_op = 3'd4;
    step();
    cmd_valid = 1'b0;
    begin
      int w;
      w = 0;
      while (!(writeEn && writeRegSel == 3'd3) && w < 20) begin step(); w++; end
      check("clr_reach_sel3", {31'd0, writeEn}, 32'd1);
    end
    rst = 1'b1;
    #1;
    check("rst_mid_clr_drive", {30'd0, enable, writeEn}, 32'd0);
    step(); step();
    check("rst_mid_clr_norsp", {31'd0, rsp_valid}, 32'd0);
    rst = 1'b0;
    step();
    do_cmd(3'd0, 3'd2, 3'd3, 16'h0, d1, d2, err, lat, we_n, saw_en, sel_ok);
    check("rst_clr_r2_r3", {d1, d2}, 32'h0000FFFF);
    do_cmd(3'd0, 3'd4, 3'd7, 16'h0, d1, d2, err, lat, we_n, saw_en, sel_ok);
    check("rst_clr_r4_r7", {d1, d2}, 32'hFFFFFFFF);
`else
    check("clr_dis_err", {31'd0, err}, 32'd1);
    check("clr_dis_lat", 32'(lat), 32'd2);
    check("clr_dis_no_enable", {31'd0, saw_en}, 32'd0);
    do_cmd(3'd0, 3'd0, 3'd7, 16'h0, d1, d2, err, lat, we_n, saw_en, sel_ok);
    check("clr_dis_readback", {d1, d2}, 32'hFFFFFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
